// File: rtl/multi_digit_lock.sv
// multi_digit_lock: programmable multi-digit code lock with retry counting,
// timed lockout and in-field re-programming of the stored code.
//
// Ports:
//   clk        - rising-edge clock
//   reset_n    - asynchronous active-low reset
//   digit_in   - digit value, sampled on cycles with enter=1
//   enter      - consume one digit per high cycle
//   clear      - abort partial entry / programming (beats enter)
//   relock     - leave UNLOCKED (beats prog_en)
//   prog_en    - with enter while UNLOCKED, start programming a new code
//   locked     - high unless UNLOCKED or PROGRAM
//   unlocked   - high in UNLOCKED or PROGRAM
//   lockout    - high while locked out after too many failures
//   error      - one-cycle pulse on a failed attempt
//   digit_idx  - digits captured in the current sequence
//   fail_count - consecutive failed attempts
module multi_digit_lock #(
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned CODE_LEN       = 4,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = {4'h1, 4'h0, 4'h1, 4'h1}
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [DIGIT_W-1:0]                digit_in,
  input  logic                              enter,
  input  logic                              clear,
  input  logic                              relock,
  input  logic                              prog_en,
  output logic                              locked,
  output logic                              unlocked,
  output logic                              lockout,
  output logic                              error,
  output logic [$clog2(CODE_LEN+1)-1:0]     digit_idx,
  output logic [$clog2(MAX_TRIES+1)-1:0]    fail_count
);

  localparam int unsigned CODE_W = CODE_LEN * DIGIT_W;
  localparam int unsigned IDX_W  = $clog2(CODE_LEN + 1);
  localparam int unsigned FC_W   = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMR_W  = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [1:0] {StEntry, StUnlocked, StProgram, StLockout} state_e;

  state_e             state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [CODE_W-1:0]  shadow_q, shadow_d;
  logic               mismatch_q, mismatch_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FC_W-1:0]    fail_q, fail_d;
  logic               error_q, error_d;

  logic [DIGIT_W-1:0] cur_digit;
  logic [CODE_W-1:0]  shadow_wr;
  logic               last_digit;
  logic               mism_all;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StEntry;
      code_q     <= DEFAULT_CODE;
      shadow_q   <= '0;
      mismatch_q <= 1'b0;
      timer_q    <= '0;
      idx_q      <= '0;
      fail_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      shadow_q   <= shadow_d;
      mismatch_q <= mismatch_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      fail_q     <= fail_d;
      error_q    <= error_d;
    end
  end

  // Next state and datapath
  always_comb begin
    // Digit 0 lives in the MSBs of both code_q and shadow_q.
    cur_digit = '0;
    shadow_wr = shadow_q;
    for (int unsigned i = 0; i < CODE_LEN; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = code_q[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
        shadow_wr[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit_in;
      end
    end
    last_digit = (idx_q == IDX_W'(CODE_LEN - 1));
    mism_all   = mismatch_q | (digit_in != cur_digit);

    state_d    = state_q;
    code_d     = code_q;
    shadow_d   = shadow_q;
    mismatch_d = mismatch_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    fail_d     = fail_q;
    error_d    = 1'b0;

    unique case (state_q)
      StEntry: begin
        if (clear) begin
          idx_d      = '0;
          mismatch_d = 1'b0;
        end else if (enter) begin
          if (last_digit) begin
            idx_d      = '0;
            mismatch_d = 1'b0;
            if (!mism_all) begin
              state_d = StUnlocked;
              fail_d  = '0;
            end else begin
              error_d = 1'b1;
              if (fail_q < FC_W'(MAX_TRIES)) fail_d = fail_q + 1'b1;
              if (fail_d == FC_W'(MAX_TRIES)) begin
                state_d = StLockout;
                timer_d = TMR_W'(LOCKOUT_CYCLES);
              end
            end
          end else begin
            idx_d      = idx_q + 1'b1;
            mismatch_d = mism_all;
          end
        end
      end
      StUnlocked: begin
        if (relock) begin
          state_d = StEntry;
          idx_d   = '0;
        end else if (prog_en && enter) begin
          state_d = StProgram;
          idx_d   = '0;
        end
      end
      StProgram: begin
        if (clear) begin
          state_d = StUnlocked;
          idx_d   = '0;
        end else if (enter) begin
          shadow_d = shadow_wr;
          if (last_digit) begin
            code_d  = shadow_wr;
            idx_d   = '0;
            state_d = StUnlocked;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StLockout: begin
        // timer==1 is the last lockout cycle; all user inputs ignored here.
        if (timer_q <= TMR_W'(1)) begin
          timer_d = '0;
          state_d = StEntry;
          fail_d  = '0;
          idx_d   = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = StEntry;
    endcase
  end

  // Outputs, decoded from registered state
  always_comb begin
    unlocked   = (state_q == StUnlocked) || (state_q == StProgram);
    locked     = !unlocked;
    lockout    = (state_q == StLockout);
    error      = error_q;
    digit_idx  = idx_q;
    fail_count = fail_q;
  end

endmodule

// File: tb/tb_multi_digit_lock.sv
module tb_multi_digit_lock;

  logic       clk;
  logic       reset_n;
  logic [3:0] digit_in;
  logic       enter, clear, relock, prog_en;
  logic       locked, unlocked, lockout, error;
  logic [2:0] digit_idx;
  logic [1:0] fail_count;

  int checks   = 0;
  int failures = 0;

  multi_digit_lock dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .digit_in   (digit_in),
    .enter      (enter),
    .clear      (clear),
    .relock     (relock),
    .prog_en    (prog_en),
    .locked     (locked),
    .unlocked   (unlocked),
    .lockout    (lockout),
    .error      (error),
    .digit_idx  (digit_idx),
    .fail_count (fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_digit(input logic [3:0] d);
    digit_in = d;
    enter    = 1'b1;
    tick();
    enter    = 1'b0;
  endtask

  task automatic do_relock();
    relock = 1'b1;
    tick();
    relock = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; digit_in = '0; enter = 0; clear = 0; relock = 0; prog_en = 0;
    #12;
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL reset_locked got=%b exp=1", locked); end
    checks++; if (unlocked !== 1'b0) begin failures++; $display("FAIL reset_unlocked got=%b exp=0", unlocked); end
    checks++; if (lockout !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL reset_lockout_error got=%b%b exp=00", lockout, error); end
    checks++; if (digit_idx !== 3'd0 || fail_count !== 2'd0) begin failures++; $display("FAIL reset_counters idx=%0d fc=%0d exp=0,0", digit_idx, fail_count); end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_unlock();
    enter_digit(4'h1);
    enter_digit(4'h0);
    checks++; if (digit_idx !== 3'd2) begin failures++; $display("FAIL unlock_idx2 got=%0d exp=2", digit_idx); end
    enter_digit(4'h1);
    checks++; if (unlocked !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL unlock_early unlocked=%b error=%b exp=0,0", unlocked, error); end
    enter_digit(4'h1);
    checks++; if (unlocked !== 1'b1 || locked !== 1'b0) begin failures++; $display("FAIL unlock_rise unlocked=%b locked=%b exp=1,0", unlocked, locked); end
    checks++; if (fail_count !== 2'd0 || error !== 1'b0 || digit_idx !== 3'd0) begin failures++; $display("FAIL unlock_status fc=%0d err=%b idx=%0d exp=0,0,0", fail_count, error, digit_idx); end
    do_relock();
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL relock got=%b exp=1", locked); end
  endtask

  task automatic test_wrong();
    enter_digit(4'h1); enter_digit(4'h1); enter_digit(4'h1);
    checks++; if (error !== 1'b0 || digit_idx !== 3'd3 || locked !== 1'b1) begin failures++; $display("FAIL wrong_pre err=%b idx=%0d locked=%b exp=0,3,1", error, digit_idx, locked); end
    enter_digit(4'h1);
    checks++; if (error !== 1'b1 || fail_count !== 2'd1) begin failures++; $display("FAIL wrong_err err=%b fc=%0d exp=1,1", error, fail_count); end
    checks++; if (digit_idx !== 3'd0 || locked !== 1'b1 || lockout !== 1'b0) begin failures++; $display("FAIL wrong_state idx=%0d locked=%b lockout=%b exp=0,1,0", digit_idx, locked, lockout); end
    tick();
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL wrong_pulse err=%b exp=0", error); end
  endtask

  task automatic test_lockout();
    int cnt;
    for (int i = 0; i < 4; i++) enter_digit(4'h0);
    checks++; if (fail_count !== 2'd2 || lockout !== 1'b0) begin failures++; $display("FAIL lockout_fc2 fc=%0d lockout=%b exp=2,0", fail_count, lockout); end
    for (int i = 0; i < 4; i++) enter_digit(4'h0);
    checks++; if (lockout !== 1'b1 || error !== 1'b1 || fail_count !== 2'd3) begin failures++; $display("FAIL lockout_enter lockout=%b err=%b fc=%0d exp=1,1,3", lockout, error, fail_count); end
    digit_in = 4'h0;
    enter    = 1'b1;
    clear    = 1'b1;
    cnt      = 0;
    while (lockout && cnt < 40) begin
      cnt++;
      tick();
    end
    clear = 1'b0;
    checks++; if (cnt != 16) begin failures++; $display("FAIL lockout_len got=%0d exp=16", cnt); end
    checks++; if (fail_count !== 2'd0 || digit_idx !== 3'd0 || locked !== 1'b1) begin failures++; $display("FAIL lockout_exit fc=%0d idx=%0d locked=%b exp=0,0,1", fail_count, digit_idx, locked); end
    // First ENTRY cycle after lockout accepts a digit.
    enter_digit(4'h1); enter_digit(4'h0); enter_digit(4'h1); enter_digit(4'h1);
    checks++; if (unlocked !== 1'b1) begin failures++; $display("FAIL lockout_then_unlock got=%b exp=1", unlocked); end
    do_relock();
  endtask

  task automatic test_clear();
    enter_digit(4'h1); enter_digit(4'h0);
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if (digit_idx !== 3'd0 || error !== 1'b0) begin failures++; $display("FAIL clear_idx idx=%0d err=%b exp=0,0", digit_idx, error); end
    enter_digit(4'h1); enter_digit(4'h0); enter_digit(4'h1);
    clear = 1'b1; enter_digit(4'h1); clear = 1'b0;
    checks++; if (locked !== 1'b1 || error !== 1'b0 || digit_idx !== 3'd0 || fail_count !== 2'd0) begin failures++; $display("FAIL clear_last locked=%b err=%b idx=%0d fc=%0d exp=1,0,0,0", locked, error, digit_idx, fail_count); end
    enter_digit(4'h1); enter_digit(4'h0); enter_digit(4'h1); enter_digit(4'h1);
    checks++; if (unlocked !== 1'b1 || fail_count !== 2'd0) begin failures++; $display("FAIL clear_unlock unlocked=%b fc=%0d exp=1,0", unlocked, fail_count); end
  endtask

  task automatic test_program();
    prog_en = 1'b1; enter_digit(4'h5); prog_en = 1'b0;
    checks++; if (unlocked !== 1'b1 || digit_idx !== 3'd0) begin failures++; $display("FAIL prog_start unlocked=%b idx=%0d exp=1,0", unlocked, digit_idx); end
    enter_digit(4'h1); enter_digit(4'h2);
    checks++; if (digit_idx !== 3'd2) begin failures++; $display("FAIL prog_idx got=%0d exp=2", digit_idx); end
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if (unlocked !== 1'b1 || digit_idx !== 3'd0) begin failures++; $display("FAIL prog_clear unlocked=%b idx=%0d exp=1,0", unlocked, digit_idx); end
    do_relock();
    enter_digit(4'h1); enter_digit(4'h0); enter_digit(4'h1); enter_digit(4'h1);
    checks++; if (unlocked !== 1'b1) begin failures++; $display("FAIL prog_old_code got=%b exp=1", unlocked); end
    prog_en = 1'b1; enter_digit(4'h5); prog_en = 1'b0;
    enter_digit(4'h9); enter_digit(4'h8);
    relock = 1'b1; enter_digit(4'h7); relock = 1'b0;
    checks++; if (unlocked !== 1'b1 || digit_idx !== 3'd3) begin failures++; $display("FAIL prog_relock_ign unlocked=%b idx=%0d exp=1,3", unlocked, digit_idx); end
    enter_digit(4'h6);
    checks++; if (unlocked !== 1'b1 || digit_idx !== 3'd0) begin failures++; $display("FAIL prog_done unlocked=%b idx=%0d exp=1,0", unlocked, digit_idx); end
    relock = 1'b1; prog_en = 1'b1; enter_digit(4'h3); relock = 1'b0; prog_en = 1'b0;
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL relock_prio locked=%b exp=1", locked); end
    enter_digit(4'h1); enter_digit(4'h0); enter_digit(4'h1); enter_digit(4'h1);
    checks++; if (error !== 1'b1 || fail_count !== 2'd1 || locked !== 1'b1) begin failures++; $display("FAIL prog_old_rej err=%b fc=%0d locked=%b exp=1,1,1", error, fail_count, locked); end
    enter_digit(4'h9); enter_digit(4'h8); enter_digit(4'h7); enter_digit(4'h6);
    checks++; if (unlocked !== 1'b1 || fail_count !== 2'd0) begin failures++; $display("FAIL prog_new_code unlocked=%b fc=%0d exp=1,0", unlocked, fail_count); end
  endtask

  task automatic test_reset_mid();
    do_relock();
    enter_digit(4'h9); enter_digit(4'h8);
    reset_n = 1'b0;
    #1;
    checks++; if (digit_idx !== 3'd0 || locked !== 1'b1 || unlocked !== 1'b0) begin failures++; $display("FAIL rst_mid_entry idx=%0d locked=%b unlocked=%b exp=0,1,0", digit_idx, locked, unlocked); end
    #1 reset_n = 1'b1;
    enter_digit(4'h1); enter_digit(4'h0); enter_digit(4'h1); enter_digit(4'h1);
    checks++; if (unlocked !== 1'b1) begin failures++; $display("FAIL rst_default_code got=%b exp=1", unlocked); end
    do_relock();
    for (int i = 0; i < 12; i++) enter_digit(4'h0);
    tick(); tick(); tick();
    checks++; if (lockout !== 1'b1) begin failures++; $display("FAIL rst_pre_lockout got=%b exp=1", lockout); end
    reset_n = 1'b0;
    #1;
    checks++; if (lockout !== 1'b0 || fail_count !== 2'd0 || locked !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL rst_mid_lockout lockout=%b fc=%0d locked=%b err=%b exp=0,0,1,0", lockout, fail_count, locked, error); end
    #1 reset_n = 1'b1;
    enter_digit(4'h1); enter_digit(4'h0); enter_digit(4'h1); enter_digit(4'h1);
    checks++; if (unlocked !== 1'b1) begin failures++; $display("FAIL rst_after_lockout got=%b exp=1", unlocked); end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_wrong();
    test_lockout();
    test_clear();
    test_program();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
